// File: rtl/dtpu_pkg.sv
// rtl/dtpu_pkg.sv - shared state encoding and width helpers for the stream engine
package dtpu_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_LOAD  = 4'd1,
    ST_ISSUE = 4'd2,
    ST_DRAIN = 4'd3,
    ST_DONE  = 4'd4
  } state_t;

  // Index width that stays legal when the indexed range has a single entry.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dtpu_stream_engine_if.sv
// rtl/dtpu_stream_engine_if.sv - input FIFO, output FIFO and MXU data ports of the stream engine
interface dtpu_stream_engine_if #(
  parameter int DATA_WIDTH_FIFO_IN  = 64,
  parameter int DATA_WIDTH_FIFO_OUT = 64,
  parameter int COLUMNS             = 3,
  parameter int ROWS                = 3
);

  logic [DATA_WIDTH_FIFO_IN-1:0]           infifo_dout;
  logic                                    infifo_is_empty;
  logic                                    infifo_read;
  logic [DATA_WIDTH_FIFO_OUT-1:0]          outfifo_din;
  logic                                    outfifo_write;
  logic                                    outfifo_is_full;
  logic [COLUMNS*DATA_WIDTH_FIFO_IN-1:0]   mxu_input_data;
  logic                                    mxu_issue;
  logic [ROWS*DATA_WIDTH_FIFO_OUT-1:0]     mxu_y;

  modport master (
    input  infifo_dout, infifo_is_empty, outfifo_is_full, mxu_y,
    output infifo_read, outfifo_din, outfifo_write, mxu_input_data, mxu_issue
  );

  modport slave (
    output infifo_dout, infifo_is_empty, outfifo_is_full, mxu_y,
    input  infifo_read, outfifo_din, outfifo_write, mxu_input_data, mxu_issue
  );

endinterface

// File: rtl/dtpu_result_buffer.sv
// rtl/dtpu_result_buffer.sv - circular buffer of MXU results with a row-by-row output serialiser
module dtpu_result_buffer
  import dtpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ROWS  = 3,
  parameter int WIDTH = 64,
  localparam int PTR_W = idx_width(DEPTH),
  localparam int CNT_W = idx_width(DEPTH + 1),
  localparam int ROW_W = idx_width(ROWS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [ROWS*WIDTH-1:0] push_data,
  input  logic                  ser_en,
  input  logic                  out_full,
  output logic [CNT_W-1:0]      count,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_write
);

  logic [ROWS-1:0][WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]           wr_ptr;
  logic [PTR_W-1:0]           rd_ptr;
  logic [ROW_W-1:0]           row_idx;
  logic                       last_row;
  logic                       pop;

  assign last_row  = row_idx == ROW_W'(ROWS - 1);
  assign out_write = ser_en && (count != '0) && !out_full;
  assign out_data  = mem[rd_ptr][row_idx];
  assign pop       = out_write && last_row;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      row_idx <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (out_write) row_idx <= last_row ? '0 : row_idx + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      // A push and a pop in the same cycle cancel out in the occupancy count.
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  overflow_check: assert property (@(posedge clk) disable iff (reset)
    !(push && !pop && (count == CNT_W'(DEPTH))));

endmodule

// File: rtl/dtpu_stream_engine.sv
// rtl/dtpu_stream_engine.sv - batch sequencer: gather vectors from the input FIFO, issue to the MXU,
// collect fixed-latency results and serialise them to the output FIFO under credit flow control
module dtpu_stream_engine
  import dtpu_pkg::*;
#(
  parameter int DATA_WIDTH_FIFO_IN  = 64,
  parameter int DATA_WIDTH_FIFO_OUT = 64,
  parameter int COLUMNS             = 3,
  parameter int ROWS                = 3,
  parameter int MXU_LATENCY         = 4,
  parameter int OUT_DEPTH           = 4,
  parameter int BATCH_WIDTH         = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cs_start,
  input  logic                   cs_continue,
  output logic                   cs_ready,
  output logic                   cs_done,
  output logic                   cs_idle,
  input  logic [BATCH_WIDTH-1:0] batch_len,
  dtpu_stream_engine_if.master   bus,
  output logic [3:0]             state_out
);

  localparam int WIDX_W = idx_width(COLUMNS);
  localparam int CNT_W  = idx_width(OUT_DEPTH + 1);
  localparam int INFL_W = idx_width(MXU_LATENCY + 1);

  state_t                                     state;
  state_t                                     state_n;
  logic [BATCH_WIDTH-1:0]                     batch_reg;
  logic [BATCH_WIDTH-1:0]                     vec_cnt;
  logic [WIDX_W-1:0]                          word_idx;
  logic [COLUMNS-1:0][DATA_WIDTH_FIFO_IN-1:0] lanes;
  logic [MXU_LATENCY-1:0]                     valid_pipe;
  logic [INFL_W-1:0]                          inflight_count;
  logic [CNT_W-1:0]                           buf_count;
  logic                                       rd;
  logic                                       issue;
  logic                                       credit_ok;
  logic                                       last_word;
  logic                                       last_vec;
  logic                                       ser_en;
  logic [DATA_WIDTH_FIFO_OUT-1:0]             ser_data;
  logic                                       ser_write;

  // Every slot in the result buffer is either occupied or reserved by an in-flight result.
  assign inflight_count = INFL_W'($countones(valid_pipe));
  assign credit_ok      = (int'(buf_count) + int'(inflight_count)) < OUT_DEPTH;
  assign last_word      = word_idx == WIDX_W'(COLUMNS - 1);
  assign last_vec       = (vec_cnt + BATCH_WIDTH'(1)) == batch_reg;
  assign ser_en         = (state != ST_IDLE) && (state != ST_DONE);

  assign cs_idle            = state == ST_IDLE;
  assign cs_ready           = state == ST_IDLE;
  assign cs_done            = state == ST_DONE;
  assign state_out          = state;
  assign bus.infifo_read    = rd;
  assign bus.mxu_issue      = issue;
  assign bus.mxu_input_data = lanes;
  assign bus.outfifo_din    = ser_data;
  assign bus.outfifo_write  = ser_write;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    rd      = 1'b0;
    issue   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (cs_start) state_n = (batch_len == '0) ? ST_DONE : ST_LOAD;
      end
      ST_LOAD: begin
        rd = !bus.infifo_is_empty;
        if (rd && last_word) state_n = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (credit_ok) begin
          issue   = 1'b1;
          state_n = last_vec ? ST_DRAIN : ST_LOAD;
        end
      end
      ST_DRAIN: begin
        if (inflight_count == '0 && buf_count == '0) state_n = ST_DONE;
      end
      ST_DONE: begin
        if (cs_continue) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      batch_reg  <= '0;
      vec_cnt    <= '0;
      word_idx   <= '0;
      lanes      <= '0;
      valid_pipe <= '0;
    end else begin
      valid_pipe <= (valid_pipe << 1) | MXU_LATENCY'(issue);
      if (state == ST_IDLE && cs_start) begin
        batch_reg <= batch_len;
        vec_cnt   <= '0;
      end
      if (rd) begin
        lanes[word_idx] <= bus.infifo_dout;
        word_idx        <= last_word ? '0 : word_idx + 1'b1;
      end
      if (issue) vec_cnt <= vec_cnt + 1'b1;
    end
  end

  dtpu_result_buffer #(
    .DEPTH (OUT_DEPTH),
    .ROWS  (ROWS),
    .WIDTH (DATA_WIDTH_FIFO_OUT)
  ) u_result_buffer (
    .clk       (clk),
    .reset     (reset),
    .push      (valid_pipe[MXU_LATENCY-1]),
    .push_data (bus.mxu_y),
    .ser_en    (ser_en),
    .out_full  (bus.outfifo_is_full),
    .count     (buf_count),
    .out_data  (ser_data),
    .out_write (ser_write)
  );

endmodule

// File: tb/tb_dtpu_stream_engine.sv
// tb/tb_dtpu_stream_engine.sv - randomized scoreboard bench for dtpu_stream_engine
module tb_dtpu_stream_engine;

  localparam int WI = 64;
  localparam int WO = 64;
  localparam int C  = 3;
  localparam int R  = 3;
  localparam int L  = 4;
  localparam int D  = 4;
  localparam int BW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          cs_start = 1'b0;
  logic          cs_continue = 1'b0;
  logic          cs_ready;
  logic          cs_done;
  logic          cs_idle;
  logic [BW-1:0] batch_len = '0;
  logic [3:0]    state_out;

  always #5 clk = ~clk;

  dtpu_stream_engine_if #(.DATA_WIDTH_FIFO_IN(WI), .DATA_WIDTH_FIFO_OUT(WO), .COLUMNS(C), .ROWS(R)) bus ();

  dtpu_stream_engine #(
    .DATA_WIDTH_FIFO_IN(WI), .DATA_WIDTH_FIFO_OUT(WO), .COLUMNS(C), .ROWS(R),
    .MXU_LATENCY(L), .OUT_DEPTH(D), .BATCH_WIDTH(BW)
  ) dut (
    .clk(clk), .reset(reset), .cs_start(cs_start), .cs_continue(cs_continue),
    .cs_ready(cs_ready), .cs_done(cs_done), .cs_idle(cs_idle), .batch_len(batch_len),
    .bus(bus), .state_out(state_out)
  );

  logic [WI-1:0]   in_q[$];
  logic [C*WI-1:0] exp_vec_q[$];
  logic [WO-1:0]   exp_q[$];
  int n_cmp = 0, n_fail = 0, n_rd = 0, n_issue = 0, n_wr = 0;
  bit starve = 0, full_hold = 0, rand_full = 0, phase = 0, rd_seen = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: DUT activity with nothing expected", name);
  endtask

  // MXU model: echoes the issued lanes onto the result rows L cycles later, zero-padded.
  logic [C*WI-1:0] ydl [L];
  always @(posedge clk) begin
    ydl[0] <= bus.mxu_input_data;
    for (int i = 1; i < L; i++) ydl[i] <= ydl[i-1];
  end
  always_comb begin
    bus.mxu_y = '0;
    for (int r = 0; r < R; r++)
      if (r < C) bus.mxu_y[r*WO +: WO] = WO'(ydl[L-1][r*WI +: WI]);
  end

  // Input/output FIFO environment, updated just after each clock edge.
  always @(posedge clk) rd_seen <= bus.infifo_read;
  initial begin
    logic [WI-1:0] tmp;
    bus.infifo_dout = '0;
    bus.infifo_is_empty = 1'b1;
    bus.outfifo_is_full = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rd_seen && in_q.size() > 0) tmp = in_q.pop_front();
      phase = !phase;
      bus.infifo_is_empty = (in_q.size() == 0) || (starve && phase);
      bus.infifo_dout = (in_q.size() > 0) ? in_q[0] : '0;
      bus.outfifo_is_full = full_hold || (rand_full && ($urandom_range(0, 3) == 0));
    end
  end

  // Monitor: pops expected vectors/words as the DUT presents them.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.infifo_read) begin
        n_rd++;
        check("read_while_empty", bus.infifo_is_empty, 0);
      end
      if (bus.mxu_issue) begin
        n_issue++;
        if (exp_vec_q.size() == 0) unexpected("mxu_issue");
        else check("mxu_lanes", bus.mxu_input_data, exp_vec_q.pop_front());
      end
      if (bus.outfifo_write) begin
        n_wr++;
        check("write_while_full", bus.outfifo_is_full, 0);
        if (exp_q.size() == 0) unexpected("outfifo_write");
        else check("out_word", bus.outfifo_din, exp_q.pop_front());
      end
    end
  end

  task automatic load_job(input int n, input bit fixed);
    logic [C*WI-1:0] vec;
    logic [WI-1:0]   w;
    for (int v = 0; v < n; v++) begin
      for (int k = 0; k < C; k++) begin
        w = fixed ? WI'(v * C + k + 1) : {$urandom, $urandom};
        vec[k*WI +: WI] = w;
        in_q.push_back(w);
      end
      exp_vec_q.push_back(vec);
      for (int r = 0; r < R; r++) exp_q.push_back((r < C) ? WO'(vec[r*WI +: WI]) : '0);
    end
  endtask

  task automatic start_job(input int n);
    batch_len = BW'(n);
    cs_start = 1'b1;
    @(negedge clk);
    cs_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max_cyc);
    int c = 0;
    while (cs_done !== 1'b1 && c < max_cyc) begin
      @(negedge clk);
      c++;
    end
    check({tag, "_done"}, cs_done, 1);
    check({tag, "_words_left"}, exp_q.size(), 0);
    check({tag, "_vecs_left"}, exp_vec_q.size(), 0);
  endtask

  task automatic release_done(input string tag);
    cs_continue = 1'b1;
    @(negedge clk);
    cs_continue = 1'b0;
    check({tag, "_idle"}, cs_idle, 1);
    check({tag, "_state"}, state_out, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_idle"}, cs_idle, 1);
    check({tag, "_ready"}, cs_ready, 1);
    check({tag, "_done"}, cs_done, 0);
    check({tag, "_state"}, state_out, 0);
    check({tag, "_rd"}, bus.infifo_read, 0);
    check({tag, "_issue"}, bus.mxu_issue, 0);
    check({tag, "_write"}, bus.outfifo_write, 0);
    check({tag, "_lanes"}, bus.mxu_input_data, 0);
    check({tag, "_din"}, bus.outfifo_din, 0);
  endtask

  initial begin
    int rd0, is0, wr0, c, done_cyc, n;
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    @(negedge clk);

    // Basic job with known words 1..6.
    is0 = n_issue; wr0 = n_wr;
    load_job(2, 1);
    start_job(2);
    wait_done("basic", 200);
    check("basic_issues", n_issue - is0, 2);
    check("basic_words", n_wr - wr0, 6);
    release_done("basic");

    // Empty batch.
    rd0 = n_rd; is0 = n_issue; wr0 = n_wr;
    start_job(0);
    check("empty_state", state_out, 4);
    check("empty_done", cs_done, 1);
    check("empty_reads", n_rd - rd0, 0);
    check("empty_issues", n_issue - is0, 0);
    check("empty_writes", n_wr - wr0, 0);
    release_done("empty");

    // Backpressure: only OUT_DEPTH vectors may be issued while the output is full.
    full_hold = 1; is0 = n_issue; wr0 = n_wr;
    load_job(8, 0);
    start_job(8);
    repeat (60) @(negedge clk);
    check("bp_issues", n_issue - is0, D);
    check("bp_state", state_out, 2);
    check("bp_writes", n_wr - wr0, 0);
    full_hold = 0;
    wait_done("bp", 400);
    check("bp_total_words", n_wr - wr0, 8 * R);
    release_done("bp");

    // Input starvation.
    starve = 1; wr0 = n_wr;
    load_job(4, 0);
    start_job(4);
    wait_done("starve", 400);
    check("starve_words", n_wr - wr0, 4 * R);
    release_done("starve");
    starve = 0;

    // Randomized jobs with random output backpressure.
    rand_full = 1;
    for (int j = 0; j < 4; j++) begin
      n = $urandom_range(1, 6);
      starve = $urandom_range(0, 1);
      wr0 = n_wr;
      load_job(n, 0);
      start_job(n);
      wait_done("rand", 600);
      check("rand_words", n_wr - wr0, n * R);
      release_done("rand");
    end
    rand_full = 0; starve = 0;

    // cs_continue held high: cs_done lasts exactly one cycle.
    cs_continue = 1'b1;
    load_job(3, 0);
    start_job(3);
    done_cyc = 0; c = 0;
    while (c < 300) begin
      if (cs_done) done_cyc++;
      if (done_cyc > 0 && cs_idle) break;
      @(negedge clk);
      c++;
    end
    cs_continue = 1'b0;
    check("cont_done_cycles", done_cyc, 1);
    check("cont_words_left", exp_q.size(), 0);

    // cs_start during DONE is ignored.
    load_job(1, 0);
    start_job(1);
    wait_done("sid", 200);
    start_job(5);
    check("sid_state", state_out, 4);
    rd0 = n_rd;
    release_done("sid");
    repeat (5) @(negedge clk);
    check("sid_no_reads", n_rd - rd0, 0);

    // Reset with vectors in flight.
    full_hold = 1; is0 = n_issue;
    load_job(4, 0);
    start_job(4);
    c = 0;
    while (n_issue - is0 < 2 && c < 100) begin
      @(negedge clk);
      #1;
      c++;
    end
    check("mr_two_issued", n_issue - is0, 2);
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check_reset_outputs("mid_reset");
    in_q.delete(); exp_q.delete(); exp_vec_q.delete();
    full_hold = 0;
    @(negedge clk);
    @(negedge clk);
    #1 reset = 1'b0;
    wr0 = n_wr;
    repeat (20) @(negedge clk);
    check("mr_no_writes", n_wr - wr0, 0);
    check("mr_idle", cs_idle, 1);
    load_job(3, 0);
    start_job(3);
    wait_done("post_reset", 300);
    check("post_reset_words", n_wr - wr0, 3 * R);
    release_done("post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d compared so far", n_cmp);
    $fatal(1);
  end

endmodule
